fma16_vector_checker: RTL and testbench

//   Synthesizable self-check sequencer for the combinational fma16 unit. It fetches
//   76-bit test vectors from a synchronous ROM and drives x/y/z/ctrl into fma16. It

---
 rtl/fma16_pkg.sv | 43 ++++
 rtl/fma16_vector_checker.sv | 208 ++++++++++++++++++++
 tb/tb_fma16_vector_checker.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/fma16_pkg.sv
// fma16_pkg: shared definitions for the fma16 vector checker.
//   - bit offsets of the 76-bit test vector fields
//   - vec_t, the packed view of one ROM word
//   - state_t, the checker sequencer states
//   - ctrl byte bit positions (end marker and fma16 controls)
package fma16_pkg;

    localparam int VEC_W  = 76;

    localparam int X_LSB    = 60;
    localparam int Y_LSB    = 44;
    localparam int Z_LSB    = 28;
    localparam int CTRL_LSB = 20;
    localparam int REXP_LSB = 4;
    localparam int FEXP_LSB = 0;

    // ctrl byte layout: [7] end marker, [6] reserved, [5:4] roundmode,
    // [3] mul, [2] add, [1] negp, [0] negz
    localparam int END_BIT   = 7;
    localparam int CTRL_RM   = 4;
    localparam int CTRL_MUL  = 3;
    localparam int CTRL_ADD  = 2;
    localparam int CTRL_NEGP = 1;
    localparam int CTRL_NEGZ = 0;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] z;
        logic [7:0]  ctrl;
        logic [15:0] rexp;
        logic [3:0]  fexp;
    } vec_t;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        APPLY,
        CHECK,
        DONE
    } state_t;

endpackage

// File: rtl/fma16_vector_checker.sv
// fma16_vector_checker: self-check sequencer for the combinational fma16 unit.
// Reads test vectors from a synchronous ROM, drives fma16 operands/controls,
// compares the fma16 result with the expected value and keeps pass/fail
// statistics plus a record of the first failing vector.
//
// Ports
//   clk, reset (async, active-low), start (1-cycle pulse)
//   vec_addr/vec_rd/vec_data   ROM interface, data valid the cycle after vec_rd
//   x,y,z,mul,add,negp,negz,roundmode   drive fma16
//   result, flags              fma16 outputs
//   busy, done, pass           run status
//   vec_count, err_count       checked vectors / saturating mismatch count
//   fail_idx, fail_got, fail_exp   first mismatch of the run
//
// Build option: FMA16_CHECK_FLAGS_EN -- when defined the flags are compared
// as well as the result; otherwise only the result is compared.
//
// state | meaning
// IDLE  | waiting for start
// FETCH | ROM read issued for vector idx
// APPLY | ROM data valid; capture operands or detect end marker
// CHECK | operands stable at fma16; compare and count
// DONE  | run finished, results held until next start
module fma16_vector_checker
    import fma16_pkg::*;
#(
    parameter int ADDR_W      = 14,
    parameter int MAX_VECTORS = 10001,
    parameter int CNT_W       = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] vec_addr,
    output logic              vec_rd,
    input  logic [75:0]       vec_data,
    output logic [15:0]       x,
    output logic [15:0]       y,
    output logic [15:0]       z,
    output logic              mul,
    output logic              add,
    output logic              negp,
    output logic              negz,
    output logic [1:0]        roundmode,
    input  logic [15:0]       result,
    input  logic [3:0]        flags,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  vec_count,
    output logic [CNT_W-1:0]  err_count,
    output logic [ADDR_W-1:0] fail_idx,
    output logic [19:0]       fail_got,
    output logic [19:0]       fail_exp
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(MAX_VECTORS - 1);

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  idx_q, idx_d;
    logic [15:0]        x_q, x_d, y_q, y_d, z_q, z_d;
    logic [5:0]         ctrl_q, ctrl_d;
    logic [15:0]        rexp_q, rexp_d;
    logic [3:0]         fexp_q, fexp_d;
    logic [CNT_W-1:0]   vec_count_q, vec_count_d;
    logic [CNT_W-1:0]   err_count_q, err_count_d;
    logic [ADDR_W-1:0]  fail_idx_q, fail_idx_d;
    logic [19:0]        fail_got_q, fail_got_d;
    logic [19:0]        fail_exp_q, fail_exp_d;

    vec_t vec_in;
    logic mismatch;
    logic unused_ctrl;

    assign vec_in      = vec_t'(vec_data);
    // ctrl[6] is reserved in the vector format
    assign unused_ctrl = vec_in.ctrl[6];

`ifdef FMA16_CHECK_FLAGS_EN
    assign mismatch = (result != rexp_q) || (flags != fexp_q);
`else
    assign mismatch = (result != rexp_q);
`endif

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        x_d         = x_q;
        y_d         = y_q;
        z_d         = z_q;
        ctrl_d      = ctrl_q;
        rexp_d      = rexp_q;
        fexp_d      = fexp_q;
        vec_count_d = vec_count_q;
        err_count_d = err_count_q;
        fail_idx_d  = fail_idx_q;
        fail_got_d  = fail_got_q;
        fail_exp_d  = fail_exp_q;
        vec_rd      = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d     = FETCH;
                    idx_d       = '0;
                    vec_count_d = '0;
                    err_count_d = '0;
                    fail_idx_d  = '0;
                    fail_got_d  = '0;
                    fail_exp_d  = '0;
                end
            end
            FETCH: begin
                vec_rd  = 1'b1;
                state_d = APPLY;
            end
            APPLY: begin
                // The marker itself is never applied, so the operands keep
                // the values of the last real vector.
                if (vec_in.ctrl[END_BIT]) begin
                    state_d = DONE;
                end else begin
                    x_d     = vec_in.x;
                    y_d     = vec_in.y;
                    z_d     = vec_in.z;
                    ctrl_d  = vec_in.ctrl[5:0];
                    rexp_d  = vec_in.rexp;
                    fexp_d  = vec_in.fexp;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                vec_count_d = vec_count_q + 1'b1;
                if (mismatch) begin
                    // err_count never returns to zero within a run, so zero
                    // here means this is the first failure.
                    if (err_count_q == '0) begin
                        fail_idx_d = idx_q;
                        fail_got_d = {result, flags};
                        fail_exp_d = {rexp_q, fexp_q};
                    end
                    if (err_count_q != '1) begin
                        err_count_d = err_count_q + 1'b1;
                    end
                end
                // Stop on the last permitted address rather than wrapping.
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = FETCH;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
            ctrl_q      <= '0;
            rexp_q      <= '0;
            fexp_q      <= '0;
            vec_count_q <= '0;
            err_count_q <= '0;
            fail_idx_q  <= '0;
            fail_got_q  <= '0;
            fail_exp_q  <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            x_q         <= x_d;
            y_q         <= y_d;
            z_q         <= z_d;
            ctrl_q      <= ctrl_d;
            rexp_q      <= rexp_d;
            fexp_q      <= fexp_d;
            vec_count_q <= vec_count_d;
            err_count_q <= err_count_d;
            fail_idx_q  <= fail_idx_d;
            fail_got_q  <= fail_got_d;
            fail_exp_q  <= fail_exp_d;
        end
    end

    assign vec_addr  = idx_q;
    assign x         = x_q;
    assign y         = y_q;
    assign z         = z_q;
    assign roundmode = ctrl_q[CTRL_RM+1:CTRL_RM];
    assign mul       = ctrl_q[CTRL_MUL];
    assign add       = ctrl_q[CTRL_ADD];
    assign negp      = ctrl_q[CTRL_NEGP];
    assign negz      = ctrl_q[CTRL_NEGZ];
    assign busy      = (state_q == FETCH) || (state_q == APPLY) || (state_q == CHECK);
    assign done      = (state_q == DONE);
    assign pass      = done && (err_count_q == '0);
    assign vec_count = vec_count_q;
    assign err_count = err_count_q;
    assign fail_idx  = fail_idx_q;
    assign fail_got  = fail_got_q;
    assign fail_exp  = fail_exp_q;

endmodule

// File: tb/tb_fma16_vector_checker.sv
// Directed bench for fma16_vector_checker. Instance a uses default parameters
// with a small ROM and a table-driven fma16 stand-in; instance b uses
// MAX_VECTORS=4 with a ROM that has no end marker.
module tb_fma16_vector_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, start_a, start_b;
    int   n_vec = 0;
    int   n_err = 0;

    logic [75:0] rom_a [0:15];
    logic [75:0] rom_b [0:15];

    logic [13:0] vec_addr_a, vec_addr_b, fail_idx_a, fail_idx_b;
    logic        vec_rd_a, vec_rd_b;
    logic [75:0] vec_data_a, vec_data_b;
    logic [15:0] x_a, y_a, z_a, x_b, y_b, z_b, result_a, result_b;
    logic        mul_a, add_a, negp_a, negz_a, mul_b, add_b, negp_b, negz_b;
    logic [1:0]  rm_a, rm_b;
    logic [3:0]  flags_a, flags_b;
    logic        busy_a, done_a, pass_a, busy_b, done_b, pass_b;
    logic [31:0] vcnt_a, ecnt_a, vcnt_b, ecnt_b;
    logic [19:0] fgot_a, fexp_a, fgot_b, fexp_b;
    logic [13:0] max_addr_b;

    function automatic logic [75:0] mkvec(input logic [15:0] vx, input logic [15:0] vy,
                                          input logic [15:0] vz, input logic [7:0] vc,
                                          input logic [15:0] vr, input logic [3:0] vf);
        return {vx, vy, vz, vc, vr, vf};
    endfunction

    // fma16 stand-in covering only the operand pairs used here
    function automatic logic [15:0] fma_f(input logic [15:0] a, input logic [15:0] b,
                                          input logic [15:0] c);
        if (a == 16'h0000 || b == 16'h0000) return c;
        if (a == 16'h3C00 && b == 16'h4000 && c == 16'h0000) return 16'h4000;
        if (a == 16'h4000 && b == 16'h4000 && c == 16'h0000) return 16'h4400;
        return 16'hFFFF;
    endfunction

    assign result_a = fma_f(x_a, y_a, z_a);
    assign result_b = fma_f(x_b, y_b, z_b);
    assign flags_a  = 4'h0;
    assign flags_b  = 4'h0;

    always @(posedge clk) if (vec_rd_a) vec_data_a <= rom_a[vec_addr_a[3:0]];
    always @(posedge clk) if (vec_rd_b) vec_data_b <= rom_b[vec_addr_b[3:0]];

    always @(posedge clk)
        if (!reset) max_addr_b <= '0;
        else if (vec_rd_b && vec_addr_b > max_addr_b) max_addr_b <= vec_addr_b;

    fma16_vector_checker dut_a (
        .clk(clk), .reset(reset), .start(start_a),
        .vec_addr(vec_addr_a), .vec_rd(vec_rd_a), .vec_data(vec_data_a),
        .x(x_a), .y(y_a), .z(z_a), .mul(mul_a), .add(add_a), .negp(negp_a), .negz(negz_a),
        .roundmode(rm_a), .result(result_a), .flags(flags_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .vec_count(vcnt_a), .err_count(ecnt_a),
        .fail_idx(fail_idx_a), .fail_got(fgot_a), .fail_exp(fexp_a)
    );

    fma16_vector_checker #(.MAX_VECTORS(4)) dut_b (
        .clk(clk), .reset(reset), .start(start_b),
        .vec_addr(vec_addr_b), .vec_rd(vec_rd_b), .vec_data(vec_data_b),
        .x(x_b), .y(y_b), .z(z_b), .mul(mul_b), .add(add_b), .negp(negp_b), .negz(negz_b),
        .roundmode(rm_b), .result(result_b), .flags(flags_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .vec_count(vcnt_b), .err_count(ecnt_b),
        .fail_idx(fail_idx_b), .fail_got(fgot_b), .fail_exp(fexp_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic load_basic();
        for (int i = 0; i < 16; i++) rom_a[i] = mkvec(16'h0, 16'h0, 16'h0, 8'h80, 16'h0, 4'h0);
        rom_a[0] = mkvec(16'h3C00, 16'h4000, 16'h0000, 8'h0C, 16'h4000, 4'h0);
        rom_a[1] = mkvec(16'h4000, 16'h4000, 16'h0000, 8'h0C, 16'h4400, 4'h0);
        rom_a[2] = mkvec(16'h0000, 16'h0000, 16'h0000, 8'h2B, 16'h0000, 4'h0);
    endtask

    // Pulse start on instance a and wait for done; counts cycles with busy=1.
    // inject >= 0 pulses start again at that busy sample.
    task automatic run_a(input int inject, output int busy_cyc);
        @(negedge clk) start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        busy_cyc = 0;
        for (int i = 0; i < 200 && !done_a; i++) begin
            if (busy_a) busy_cyc++;
            if (i == inject) begin
                start_a = 1'b1;
                @(posedge clk); #1 start_a = 1'b0;
            end else begin
                @(posedge clk); #1;
            end
        end
        chk("run_done", 32'(done_a), 32'd1);
    endtask

    initial begin
        int bc;
        reset   = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        load_basic();
        for (int i = 0; i < 16; i++) rom_b[i] = mkvec(16'h4000, 16'h4000, 16'h0, 8'h0C, 16'h4400, 4'h0);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy_a), 32'd0);
        chk("rst_done", 32'(done_a), 32'd0);
        chk("rst_pass", 32'(pass_a), 32'd0);
        chk("rst_vec_rd", 32'(vec_rd_a), 32'd0);
        chk("rst_ops", {x_a, y_a}, 32'd0);
        @(negedge clk) reset = 1'b1;

        // three good vectors then marker
        run_a(-1, bc);
        chk("t1_busy_cycles", bc, 32'd11);
        chk("t1_vec_count", vcnt_a, 32'd3);
        chk("t1_err_count", ecnt_a, 32'd0);
        chk("t1_pass", 32'(pass_a), 32'd1);
        chk("t1_busy_after", 32'(busy_a), 32'd0);
        chk("t1_ctrl_hold", 32'({rm_a, mul_a, add_a, negp_a, negz_a}), 32'b101011);
        chk("t1_vec_addr", 32'(vec_addr_a), 32'd3);

        // rerun from address 0 with a start pulse while busy
        run_a(4, bc);
        chk("t1b_busy_cycles", bc, 32'd11);
        chk("t1b_vec_count", vcnt_a, 32'd3);
        chk("t1b_pass", 32'(pass_a), 32'd1);

        // corrupted rexp on vector 1
        rom_a[1] = mkvec(16'h4000, 16'h4000, 16'h0000, 8'h0C, 16'h4401, 4'h0);
        run_a(-1, bc);
        chk("t2_err_count", ecnt_a, 32'd1);
        chk("t2_fail_idx", 32'(fail_idx_a), 32'd1);
        chk("t2_fail_got", 32'(fgot_a), 32'h44000);
        chk("t2_fail_exp", 32'(fexp_a), 32'h44010);
        chk("t2_pass", 32'(pass_a), 32'd0);
        chk("t2_vec_count", vcnt_a, 32'd3);

        // second failure must not overwrite the first record
        rom_a[2] = mkvec(16'h0000, 16'h0000, 16'h0000, 8'h2B, 16'h0001, 4'h0);
        run_a(-1, bc);
        chk("t2b_err_count", ecnt_a, 32'd2);
        chk("t2b_fail_idx", 32'(fail_idx_a), 32'd1);
        chk("t2b_fail_exp", 32'(fexp_a), 32'h44010);

        // expected flags differ only
        load_basic();
        rom_a[0] = mkvec(16'h3C00, 16'h4000, 16'h0000, 8'h0C, 16'h4000, 4'h1);
        run_a(-1, bc);
`ifdef FMA16_CHECK_FLAGS_EN
        chk("t3_err_count", ecnt_a, 32'd1);
        chk("t3_fail_exp", 32'(fexp_a), 32'h40001);
`else
        chk("t3_err_count", ecnt_a, 32'd0);
        chk("t3_fail_exp", 32'(fexp_a), 32'h0);
`endif
        chk("t3_fail_idx", 32'(fail_idx_a), 32'd0);

        // no marker, MAX_VECTORS=4 on instance b
        @(negedge clk) start_b = 1'b1;
        @(posedge clk); #1 start_b = 1'b0;
        bc = 0;
        for (int i = 0; i < 200 && !done_b; i++) begin
            if (busy_b) bc++;
            @(posedge clk); #1;
        end
        chk("t4_done", 32'(done_b), 32'd1);
        chk("t4_busy_cycles", bc, 32'd12);
        chk("t4_vec_count", vcnt_b, 32'd4);
        chk("t4_max_addr", 32'(max_addr_b), 32'd3);
        chk("t4_vec_addr", 32'(vec_addr_b), 32'd3);
        chk("t4_pass", 32'(pass_b), 32'd1);

        // reset during CHECK of vector 2
        load_basic();
        @(negedge clk) start_a = 1'b1;
        @(posedge clk); #1 start_a = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("t5_pre_count", vcnt_a, 32'd2);
        chk("t5_pre_busy", 32'(busy_a), 32'd1);
        reset = 1'b0;
        #1;
        chk("t5_busy", 32'(busy_a), 32'd0);
        chk("t5_done", 32'(done_a), 32'd0);
        chk("t5_vec_count", vcnt_a, 32'd0);
        chk("t5_err_fail", {12'h0, fgot_a} | ecnt_a, 32'd0);
        chk("t5_ops", {x_a, y_a}, 32'd0);
        chk("t5_vec_addr", 32'(vec_addr_a), 32'd0);
        @(negedge clk) reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("t5_stays_idle", 32'({busy_a, done_a}), 32'd0);

        // marker at address 0
        rom_a[0] = mkvec(16'h0, 16'h0, 16'h0, 8'h80, 16'h0, 4'h0);
        run_a(-1, bc);
        chk("t6_busy_cycles", bc, 32'd2);
        chk("t6_vec_count", vcnt_a, 32'd0);
        chk("t6_pass", 32'(pass_a), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
